tc_operand_precond_pipe: RTL
============================

Name: tc_operand_precond_pipe

Overview:
Pipelined two's-complement preconditioning stage for the vector Vedic (Urdhva Tiryakbhyam) multiplier. It accepts both operands, then per SIMD lane extracts the sign and replaces negative signed elements with their magnitude. It sits directly ahead of the unsigned Vedic multiplier array and supplies the per-byte sign vectors that the output-side two's-complement stage consumes. It generalises the single-operand combinational selector: parametrised width, both operands at once, valid/ready pipelining, tag pass-through, flush, and an optional 64-bit element mode.

Parameters:
XLEN, 32, operand width in bits; 32 or 64.
TAG_W, 4, width of the opaque tag carried alongside each beat.
NB, XLEN/8, number of byte lanes (derived; not user-set).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all in-flight beats
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_opcode  in  2  00 MUL (s×s), 01 MULH (s×s), 10 MULHSU (A s, B u), 11 MULHU (u×u)
in_precision  in  2  element width: 00=8, 01=16, 10=32, 11=64
in_a  in  XLEN  operand A
in_b  in  XLEN  operand B
in_tag  in  TAG_W  opaque tag
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_a_mag  out  XLEN  lane-wise magnitude of A
out_b_mag  out  XLEN  lane-wise magnitude of B
out_sign_a  out  NB  per-byte sign of A's element
out_sign_b  out  NB  per-byte sign of B's element
out_neg_res  out  NB  out_sign_a XOR out_sign_b; product lane must be negated
out_tag  out  TAG_W  tag of the beat
out_illegal  out  1  precision unsupported for XLEN

Behaviour:
- Element width W = 8<<precision. Lane i occupies bits [i*W +: W].
- A is signed for opcodes 00/01/10. B is signed for opcodes 00/01.
- If an operand is signed and the lane MSB is 1: the lane output is ~lane+1, computed lane-locally with no carry across lanes, and every sign bit of that lane's bytes is 1. Otherwise the lane passes unchanged and its sign bits are 0.
- Most negative value (0x80 for W=8, etc.) maps to itself. It is a valid unsigned magnitude 2^(W-1).
- Precision 11 with XLEN=32 is illegal: out_illegal=1, data passes unmodified, all sign and neg_res bits are 0.
- Two registered stages:
  - S1 captures the inputs, decodes the lane masks and computes the lane sign bits.
  - S2 performs the segmented negation and holds the output registers.
- Latency is exactly 2 cycles from acceptance (in_valid & in_ready) to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Stall rules:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | S2 advances.
  - in_ready = !s1_valid | S1 advances, so bubbles collapse.
- While out_valid=1 and out_ready=0, all out_* signals are held stable.
- Beats are never dropped or reordered.
- rst or flush: s1_valid=s2_valid=0 on the next edge, so out_valid=0 and in_ready=1 the following cycle. Any input beat presented in the same cycle is discarded.
- rst also clears every output data register to 0: out_a_mag, out_b_mag, out_sign_*, out_neg_res, out_tag and out_illegal all read 0. flush clears valids only.
- Simultaneous flush with acceptance: the flush wins.

Decomposition:
- Package tc_pre_pkg holds:
  - opcode and precision enums;
  - function a_signed(op) / b_signed(op);
  - function lane_mask(precision, XLEN), returning a per-byte "lane-start" vector.
- Sub-module tc_lane_negate (XLEN parameter): combinational, segmented conditional two's complement given a data word, lane-start vector and per-byte negate vector. It is instantiated twice in S2, once for A and once for B.

Test Plan:
- XLEN=32, prec 00, op 01, A=0x80FF017F -> out_a_mag=0x8001017F, out_sign_a=4'b1100, 2 cycles after acceptance.
- prec 10, op 10, A=B=0xFFFFFFFE -> a_mag=0x00000002, sign_a=4'b1111, b_mag=0xFFFFFFFE, sign_b=4'b0000, neg_res=4'b1111.
- prec 01, op 11, A=0x8000FFFF -> passes unchanged, all signs 0. Sweep all 4 opcodes × 3 precisions with random data against a reference model; fail count must be 0.
- Offer 4 back-to-back beats with out_ready held low 3 cycles:
  - exactly 2 beats are accepted, then in_ready=0;
  - on release, all 4 beats emerge in tag order with out_* stable during the stall.
- Assert rst (and separately flush) with both stages full -> out_valid=0 next cycle; no stale beat appears afterwards. After rst, all outputs read 0.
- XLEN=64, prec 11, op 00, A=0x8000000000000000 -> mag unchanged, sign_a=8'hFF. XLEN=32, prec 11 -> out_illegal=1, data unmodified.

Source files
------------

// File: rtl/tc_pre_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tc_pre_pkg
// Brief   : Opcode/precision encodings and lane helpers for the operand
//           preconditioning pipe.
// Rev     : 1.0
// ============================================================================
package tc_pre_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    PREC_8  = 2'b00,
    PREC_16 = 2'b01,
    PREC_32 = 2'b10,
    PREC_64 = 2'b11
  } prec_e;

  localparam int MAX_NB = 8;

  function automatic logic a_signed(opcode_e op);
    return op != OP_MULHU;
  endfunction

  function automatic logic b_signed(opcode_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

  // Bit j is set when byte j is the least-significant byte of its element.
  function automatic logic [MAX_NB-1:0] lane_mask(prec_e prec, int xlen);
    logic [MAX_NB-1:0] m;
    m = '0;
    for (int j = 0; j < MAX_NB; j++) begin
      if ((j < xlen / 8) && ((j & ((1 << int'(prec)) - 1)) == 0)) m[j] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_lane_negate.sv
`default_nettype none
// ============================================================================
// Module  : tc_lane_negate
// Brief   : Segmented conditional two's complement; carries never cross lanes.
// Rev     : 1.0
// ============================================================================
module tc_lane_negate #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   data,
  input  logic [XLEN/8-1:0] lane_start,
  input  logic [XLEN/8-1:0] negate,
  output logic [XLEN-1:0]   result
);

  localparam int NB = XLEN / 8;

  logic       carry;
  logic [8:0] byte_sum;

  // The +1 of ~x+1 is injected at every lane start and rippled byte by byte.
  always_comb begin
    result   = data;
    carry    = 1'b0;
    byte_sum = '0;
    for (int j = 0; j < NB; j++) begin
      if (lane_start[j]) carry = 1'b1;
      byte_sum = {1'b0, ~data[j*8 +: 8]} + {8'd0, carry};
      if (negate[j]) begin
        result[j*8 +: 8] = byte_sum[7:0];
        carry            = byte_sum[8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tc_operand_precond_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tc_operand_precond_pipe
// Brief   : Two-stage signed-operand preconditioner feeding the Vedic array.
// Rev     : 1.0
// ============================================================================
module tc_operand_precond_pipe
  import tc_pre_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int TAG_W = 4,
  localparam int NB    = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [1:0]       in_precision,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a_mag,
  output logic [XLEN-1:0]  out_b_mag,
  output logic [NB-1:0]    out_sign_a,
  output logic [NB-1:0]    out_sign_b,
  output logic [NB-1:0]    out_neg_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  opcode_e          op;
  logic             illegal_d;
  logic [NB-1:0]    start_d, sign_a_d, sign_b_d;
  int               msb_byte;

  logic             s1_valid, s2_valid, s1_advance, s2_advance;
  logic [XLEN-1:0]  s1_a, s1_b, a_mag_d, b_mag_d;
  logic [NB-1:0]    s1_start, s1_sign_a, s1_sign_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_illegal;

  assign op         = opcode_e'(in_opcode);
  assign s2_advance = !s2_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;

  // Every byte of an element copies the element's MSB as its sign.
  always_comb begin
    illegal_d = (XLEN == 32) && (prec_e'(in_precision) == PREC_64);
    start_d   = NB'(lane_mask(prec_e'(in_precision), XLEN));
    sign_a_d  = '0;
    sign_b_d  = '0;
    msb_byte  = 0;
    for (int j = 0; j < NB; j++) begin
      msb_byte = j | ((1 << in_precision) - 1);
      if (!illegal_d && (msb_byte < NB)) begin
        sign_a_d[j] = a_signed(op) && in_a[msb_byte*8 + 7];
        sign_b_d[j] = b_signed(op) && in_b[msb_byte*8 + 7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_start   <= '0;
      s1_sign_a  <= '0;
      s1_sign_b  <= '0;
      s1_tag     <= '0;
      s1_illegal <= 1'b0;
    end else begin
      if (flush)           s1_valid <= 1'b0;
      else if (s1_advance) s1_valid <= in_valid;
      if (s1_advance && in_valid && !flush) begin
        s1_a       <= in_a;
        s1_b       <= in_b;
        s1_start   <= start_d;
        s1_sign_a  <= sign_a_d;
        s1_sign_b  <= sign_b_d;
        s1_tag     <= in_tag;
        s1_illegal <= illegal_d;
      end
    end
  end

  tc_lane_negate #(.XLEN(XLEN)) u_neg_a (
    .data       (s1_a),
    .lane_start (s1_start),
    .negate     (s1_sign_a),
    .result     (a_mag_d)
  );

  tc_lane_negate #(.XLEN(XLEN)) u_neg_b (
    .data       (s1_b),
    .lane_start (s1_start),
    .negate     (s1_sign_b),
    .result     (b_mag_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      out_a_mag   <= '0;
      out_b_mag   <= '0;
      out_sign_a  <= '0;
      out_sign_b  <= '0;
      out_neg_res <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (flush)           s2_valid <= 1'b0;
      else if (s2_advance) s2_valid <= s1_valid;
      if (s2_advance && s1_valid && !flush) begin
        out_a_mag   <= a_mag_d;
        out_b_mag   <= b_mag_d;
        out_sign_a  <= s1_sign_a;
        out_sign_b  <= s1_sign_b;
        out_neg_res <= s1_sign_a ^ s1_sign_b;
        out_tag     <= s1_tag;
        out_illegal <= s1_illegal;
      end
    end
  end

endmodule
`default_nettype wire
